// File: rtl/univ_reg_pkg.sv
// ---------------------------------------------------------------------------
// univ_reg_pkg
//
// Shared definitions for the universal register and its testbench.
//
// Contents:
//   mode_w        width of the MODE select field
//   mode_e        named operation codes driven on MODE
//   jk_e          per-bit JK control pair {J,K} decoded by univ_reg_jkbit
//   mode_name()   printable mnemonic for a mode code (useful in benches and
//                 waveform viewers)
// ---------------------------------------------------------------------------
package univ_reg_pkg;

  localparam int unsigned MODE_W = 3;

  // Operation select. Every 3-bit code is assigned, so a case on this type
  // is full without a default arm.
  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,  // keep Q, clear CO
    MODE_LOAD = 3'b001,  // Q <= D
    MODE_JK   = 3'b010,  // per-bit JK flip-flop behaviour
    MODE_SHL  = 3'b011,  // shift toward MSB, SI enters at bit 0
    MODE_SHR  = 3'b100,  // shift toward LSB, SI enters at MSB
    MODE_INC  = 3'b101,  // count up, CO flags wrap to zero
    MODE_DEC  = 3'b110,  // count down, CO flags borrow from zero
    MODE_CLR  = 3'b111   // Q <= 0
  } mode_e;

  // JK control pair as seen by one bit cell: {J[i], K[i]}.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_e;

  function automatic string mode_name(input mode_e m);
    case (m)
      MODE_HOLD: return "HOLD";
      MODE_LOAD: return "LOAD";
      MODE_JK:   return "JK";
      MODE_SHL:  return "SHL";
      MODE_SHR:  return "SHR";
      MODE_INC:  return "INC";
      MODE_DEC:  return "DEC";
      MODE_CLR:  return "CLR";
      default:   return "???";
    endcase
  endfunction

endpackage : univ_reg_pkg

// File: rtl/univ_reg_if.sv
// ---------------------------------------------------------------------------
// univ_reg_if
//
// Control/data bundle between a user of the universal register and the
// register itself. Clock and reset are not part of the bundle; they are
// plain ports on the register.
//
// Signals:
//   CE     clock enable, 0 = all state held
//   MODE   operation select (mode_e)
//   D      parallel load data            [WIDTH]
//   J, K   per-bit JK controls           [WIDTH each]
//   SI     serial input for shift modes
//   Q      register value                [WIDTH]
//   Qdash  bitwise complement of Q       [WIDTH]
//   CO     registered carry/borrow/shift-out flag
//   Z      combinational, high when Q == 0
//
// Modports:
//   master  drives CE/MODE/D/J/K/SI, observes Q/Qdash/CO/Z
//   slave   the register side (univ_reg)
// ---------------------------------------------------------------------------
interface univ_reg_if #(
  parameter int unsigned WIDTH = 8
);
  import univ_reg_pkg::*;

  logic             CE;
  mode_e            MODE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qdash;
  logic             CO;
  logic             Z;

  modport master (
    output CE, MODE, D, J, K, SI,
    input  Q, Qdash, CO, Z
  );

  modport slave (
    input  CE, MODE, D, J, K, SI,
    output Q, Qdash, CO, Z
  );

endinterface : univ_reg_if

// File: rtl/univ_reg_jkbit.sv
// ---------------------------------------------------------------------------
// univ_reg_jkbit
//
// One-bit JK next-state cell. Purely combinational: given the present bit
// value and its J/K controls it produces the value the bit would take in JK
// mode. The state itself lives in univ_reg.
//
// Ports:
//   q       present bit value
//   j, k    JK controls for this bit
//   q_next  next bit value: 00 hold, 01 clear, 10 set, 11 toggle
// ---------------------------------------------------------------------------
module univ_reg_jkbit
  import univ_reg_pkg::*;
(
  input  logic q,
  input  logic j,
  input  logic k,
  output logic q_next
);

  jk_e jk;

  assign jk = jk_e'({j, k});

  always_comb begin
    case (jk)
      JK_HOLD:   q_next = q;
      JK_CLEAR:  q_next = 1'b0;
      JK_SET:    q_next = 1'b1;
      JK_TOGGLE: q_next = ~q;
      default:   q_next = q;
    endcase
  end

endmodule : univ_reg_jkbit

// File: rtl/univ_reg.sv
// ---------------------------------------------------------------------------
// univ_reg
//
// Universal WIDTH-bit register: hold, parallel load, per-bit JK, shift
// left/right with serial input, increment, decrement and clear, selected by
// MODE and qualified by CE. One state register plus one CO flip-flop carry
// all state; Qdash and Z are derived from the state register.
//
// Parameters:
//   WIDTH        register width in bits, 2..32
//   RESET_VALUE  value loaded into Q by reset
//
// Ports:
//   CLK   single clock, all state updates on its rising edge
//   RST   synchronous, active-high reset; forces Q=RESET_VALUE, CO=0 and
//         overrides CE and MODE
//   bus   univ_reg_if.slave: CE, MODE, D, J, K, SI in; Q, Qdash, CO, Z out
//
// CO meaning by mode:
//   SHL  old Q[WIDTH-1]     SHR  old Q[0]
//   INC  old Q was all-ones DEC  old Q was zero
//   all other modes clear it
// ---------------------------------------------------------------------------
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic     CLK,
  input  logic     RST,
  univ_reg_if.slave bus
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] q_r;
  logic             co_r;

  // Candidate next state for the selected mode; only committed when CE=1.
  logic [WIDTH-1:0] q_next;
  logic             co_next;

  // Per-bit JK next values from the bit cells.
  logic [WIDTH-1:0] jk_next;

  // INC/DEC results with the carry/borrow in the extra MSB.
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;

  // -------------------------------------------------------------------------
  // JK cells, one per bit
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_jk
    univ_reg_jkbit u_jkbit (
      .q      (q_r[i]),
      .j      (bus.J[i]),
      .k      (bus.K[i]),
      .q_next (jk_next[i])
    );
  end

  // -------------------------------------------------------------------------
  // Arithmetic
  // -------------------------------------------------------------------------
  // Widening by one bit makes the wrap flag fall out of the adder: INC from
  // all-ones sets bit WIDTH, and DEC from zero borrows into bit WIDTH.
  assign inc_sum  = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = {1'b0, q_r} - {{WIDTH{1'b0}}, 1'b1};

  // -------------------------------------------------------------------------
  // Next-state selection
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; without them
    // a missed arm would infer a latch instead of combinational logic.
    q_next  = q_r;
    co_next = 1'b0;

    case (bus.MODE)
      MODE_HOLD: begin
        q_next  = q_r;
        co_next = 1'b0;
      end
      MODE_LOAD: begin
        q_next  = bus.D;
        co_next = 1'b0;
      end
      MODE_JK: begin
        q_next  = jk_next;
        co_next = 1'b0;
      end
      MODE_SHL: begin
        q_next  = {q_r[WIDTH-2:0], bus.SI};
        co_next = q_r[WIDTH-1];
      end
      MODE_SHR: begin
        q_next  = {bus.SI, q_r[WIDTH-1:1]};
        co_next = q_r[0];
      end
      MODE_INC: begin
        q_next  = inc_sum[WIDTH-1:0];
        co_next = inc_sum[WIDTH];
      end
      MODE_DEC: begin
        q_next  = dec_diff[WIDTH-1:0];
        co_next = dec_diff[WIDTH];
      end
      MODE_CLR: begin
        q_next  = '0;
        co_next = 1'b0;
      end
      default: begin
        q_next  = q_r;
        co_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // Reset is checked before CE so that an asserted RST discards whatever the
  // selected mode would have done on that edge.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order or other always_ff blocks.
    if (RST) begin
      q_r  <= RESET_VALUE;
      co_r <= 1'b0;
    end else if (bus.CE) begin
      q_r  <= q_next;
      co_r <= co_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.Q     = q_r;
  assign bus.Qdash = ~q_r;
  assign bus.CO    = co_r;
  assign bus.Z     = (q_r == '0);

endmodule : univ_reg
